// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - WB-to-CSR trap sequencer: priority pick, one-cycle CSR strobe, held flush/redirect.
module csr_trap_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter bit INT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] wb_vaddr,
  input  logic              wb_adef,
  input  logic              wb_ine,
  input  logic              wb_sys,
  input  logic              wb_brk,
  input  logic              wb_ale,
  input  logic              wb_ertn,
  input  logic              has_int,
  input  logic [ADDR_W-1:0] ex_entry,
  input  logic [ADDR_W-1:0] ertn_entry,
  output logic              csr_wb_ex,
  output logic              csr_ertn_flush,
  output logic [5:0]        csr_ecode,
  output logic [8:0]        csr_esubcode,
  output logic [ADDR_W-1:0] csr_pc,
  output logic [ADDR_W-1:0] csr_vaddr,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic [CNT_W-1:0]  trap_cnt
);

  typedef enum logic [1:0] {IDLE, TRAP, REDIR} state_t;

  state_t              state_q;
  logic                wb_ready_q, wb_ex_q, ertn_flush_q, flush_q, redirect_valid_q;
  logic [5:0]          ecode_q;
  logic [8:0]          esubcode_q;
  logic [ADDR_W-1:0]   pc_q, vaddr_q, redirect_pc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                take_int_d, exc_d, trigger_d;
  logic [5:0]          ecode_d;

  always_comb begin
    take_int_d = INT_EN & has_int;
    exc_d      = take_int_d | wb_adef | wb_ine | wb_sys | wb_brk | wb_ale;
    trigger_d  = exc_d | wb_ertn;
    // ERTN-only retirement records code 0; the ertn strobe, not the code, tells the CSR file what happened
    ecode_d    = 6'h00;
    if (take_int_d)   ecode_d = 6'h00;
    else if (wb_adef) ecode_d = 6'h08;
    else if (wb_ine)  ecode_d = 6'h0D;
    else if (wb_sys)  ecode_d = 6'h0B;
    else if (wb_brk)  ecode_d = 6'h0C;
    else if (wb_ale)  ecode_d = 6'h09;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      wb_ready_q       <= 1'b1;
      wb_ex_q          <= 1'b0;
      ertn_flush_q     <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      ecode_q          <= '0;
      esubcode_q       <= '0;
      pc_q             <= '0;
      vaddr_q          <= '0;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_valid && trigger_d) begin
            state_q      <= TRAP;
            wb_ready_q   <= 1'b0;
            wb_ex_q      <= exc_d;
            ertn_flush_q <= ~exc_d;
            flush_q      <= 1'b1;
            ecode_q      <= ecode_d;
            esubcode_q   <= 9'd0;
            pc_q         <= wb_pc;
            vaddr_q      <= wb_vaddr;
          end
        end
        TRAP: begin
          state_q          <= REDIR;
          wb_ex_q          <= 1'b0;
          ertn_flush_q     <= 1'b0;
          redirect_valid_q <= 1'b1;
          // entry is sampled while the CSR file is still seeing the strobe, i.e. its pre-update value
          redirect_pc_q    <= ertn_flush_q ? ertn_entry : ex_entry;
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
        REDIR: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            wb_ready_q       <= 1'b1;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_ready       = wb_ready_q;
  assign csr_wb_ex      = wb_ex_q;
  assign csr_ertn_flush = ertn_flush_q;
  assign csr_ecode      = ecode_q;
  assign csr_esubcode   = esubcode_q;
  assign csr_pc         = pc_q;
  assign csr_vaddr      = vaddr_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_cnt       = cnt_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - bench for csr_trap_ctrl: per-cycle model compare plus directed literal checks.
module tb_csr_trap_ctrl;
  localparam int AW = 32;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic wb_valid = 0, wb_adef = 0, wb_ine = 0, wb_sys = 0, wb_brk = 0, wb_ale = 0, wb_ertn = 0;
  logic has_int = 0, redirect_ready = 0;
  logic [AW-1:0] wb_pc = '0, wb_vaddr = '0, ex_entry = '0, ertn_entry = '0;
  logic wb_ready, csr_wb_ex, csr_ertn_flush, flush, redirect_valid;
  logic [5:0] csr_ecode;
  logic [8:0] csr_esubcode;
  logic [AW-1:0] csr_pc, csr_vaddr, redirect_pc;
  logic [CW-1:0] trap_cnt;

  int total = 0;
  int bad = 0;

  csr_trap_ctrl #(.ADDR_W(AW), .CNT_W(CW), .INT_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_adef(wb_adef), .wb_ine(wb_ine),
    .wb_sys(wb_sys), .wb_brk(wb_brk), .wb_ale(wb_ale), .wb_ertn(wb_ertn),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .csr_wb_ex(csr_wb_ex), .csr_ertn_flush(csr_ertn_flush), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .csr_pc(csr_pc), .csr_vaddr(csr_vaddr),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 = waiting for retirement, 1 = strobe cycle, 2 = waiting for redirect acceptance
  int            m_phase = 0;
  bit            m_ertn = 0;
  logic [5:0]    m_ecode = '0;
  logic [AW-1:0] m_pc = '0, m_vaddr = '0, m_rpc = '0;
  int            m_cnt = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase <= 0; m_ertn <= 0; m_ecode <= '0;
      m_pc <= '0; m_vaddr <= '0; m_rpc <= '0; m_cnt <= 0;
    end else if (m_phase == 0) begin
      if (wb_valid && (has_int || wb_adef || wb_ine || wb_sys || wb_brk || wb_ale || wb_ertn)) begin
        m_phase <= 1;
        m_pc    <= wb_pc;
        m_vaddr <= wb_vaddr;
        m_ertn  <= !(has_int || wb_adef || wb_ine || wb_sys || wb_brk || wb_ale);
        m_ecode <= has_int ? 6'h00 : wb_adef ? 6'h08 : wb_ine ? 6'h0D :
                   wb_sys  ? 6'h0B : wb_brk  ? 6'h0C : wb_ale ? 6'h09 : 6'h00;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
      m_rpc   <= m_ertn ? ertn_entry : ex_entry;
      m_cnt   <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end else if (redirect_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    chk("wb_ready", wb_ready, m_phase == 0);
    chk("csr_wb_ex", csr_wb_ex, m_phase == 1 && !m_ertn);
    chk("csr_ertn_flush", csr_ertn_flush, m_phase == 1 && m_ertn);
    chk("flush", flush, m_phase != 0);
    chk("redirect_valid", redirect_valid, m_phase == 2);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("csr_ecode", csr_ecode, m_ecode);
    chk("csr_esubcode", csr_esubcode, 0);
    chk("csr_pc", csr_pc, m_pc);
    chk("csr_vaddr", csr_vaddr, m_vaddr);
    chk("trap_cnt", trap_cnt, m_cnt);
  end

  task automatic clr();
    wb_valid = 0; has_int = 0; wb_adef = 0; wb_ine = 0; wb_sys = 0; wb_brk = 0; wb_ale = 0; wb_ertn = 0;
  endtask

  // f = {int, adef, ine, sys, brk, ale}; holds wb_valid for exactly one rising edge
  task automatic send(input logic [5:0] f, input logic ertn, input logic [AW-1:0] pc);
    has_int = f[5]; wb_adef = f[4]; wb_ine = f[3]; wb_sys = f[2]; wb_brk = f[1]; wb_ale = f[0];
    wb_ertn = ertn; wb_pc = pc; wb_vaddr = pc + 32'h100; wb_valid = 1;
    @(posedge clk); #1;
    clr();
  endtask

  logic [5:0] tbl_f [5] = '{6'b010000, 6'b001000, 6'b000010, 6'b000001, 6'b001001};
  logic [5:0] tbl_c [5] = '{6'h08, 6'h0D, 6'h0C, 6'h09, 6'h0D};
  int         tbl_n [5] = '{1, 2, 3, 3, 3};

  initial begin
    #1 resetn = 0;
    repeat (2) @(negedge clk);
    chk("reset_wb_ready", wb_ready, 1);
    chk("reset_trap_cnt", trap_cnt, 0);
    chk("reset_flush", flush, 0);
    #2 resetn = 1;
    @(posedge clk); #1;

    send(6'b000000, 0, 32'h1c000000);
    @(negedge clk);
    chk("notrig_wb_ready", wb_ready, 1);
    chk("notrig_wb_ex", csr_wb_ex, 0);
    chk("notrig_cnt", trap_cnt, 0);

    ex_entry = 32'h1c008000; redirect_ready = 1;
    send(6'b000100, 0, 32'h1c000010);
    @(negedge clk);
    chk("sys_wb_ex", csr_wb_ex, 1);
    chk("sys_ecode", csr_ecode, 6'h0B);
    chk("sys_pc", csr_pc, 32'h1c000010);
    chk("sys_vaddr", csr_vaddr, 32'h1c000110);
    @(negedge clk);
    chk("sys_redir_valid", redirect_valid, 1);
    chk("sys_redir_pc", redirect_pc, 32'h1c008000);
    @(negedge clk);
    chk("sys_idle", wb_ready, 1);
    chk("sys_cnt", trap_cnt, 1);

    send(6'b100101, 0, 32'h1c000020);
    @(negedge clk);
    chk("int_prio_ecode", csr_ecode, 6'h00);
    repeat (2) @(negedge clk);
    send(6'b000101, 0, 32'h1c000030);
    @(negedge clk);
    chk("sys_over_ale_ecode", csr_ecode, 6'h0B);
    repeat (2) @(negedge clk);

    redirect_ready = 0; ertn_entry = 32'h1c000420;
    send(6'b000000, 1, 32'h1c000040);
    @(negedge clk);
    chk("ertn_flush_strobe", csr_ertn_flush, 1);
    chk("ertn_no_wb_ex", csr_wb_ex, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ertn_hold_valid", redirect_valid, 1);
      chk("ertn_hold_flush", flush, 1);
      chk("ertn_hold_ready", wb_ready, 0);
      chk("ertn_redir_pc", redirect_pc, 32'h1c000420);
      chk("ertn_strobe_off", csr_ertn_flush, 0);
    end
    redirect_ready = 1;
    @(negedge clk);
    chk("ertn_done_ready", wb_ready, 1);
    chk("ertn_done_valid", redirect_valid, 0);
    chk("ertn_sat_cnt", trap_cnt, 3);

    redirect_ready = 0;
    send(6'b000010, 0, 32'h1c000050);
    repeat (2) @(negedge clk);
    chk("pre_reset_redir", redirect_valid, 1);
    #2 resetn = 0;
    #1;
    chk("midreset_wb_ready", wb_ready, 1);
    chk("midreset_valid", redirect_valid, 0);
    chk("midreset_flush", flush, 0);
    chk("midreset_cnt", trap_cnt, 0);
    chk("midreset_pc", csr_pc, 0);
    chk("midreset_rpc", redirect_pc, 0);
    @(negedge clk);
    #2 resetn = 1; redirect_ready = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send(tbl_f[i], 0, 32'h1c000100 + 32'(i * 4));
      @(negedge clk);
      chk("tbl_ecode", csr_ecode, tbl_c[i]);
      repeat (2) @(negedge clk);
      chk("tbl_cnt", trap_cnt, tbl_n[i]);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
